// File: rtl/avl_burst_pkg.sv
// Shared types and defaults for the Avalon burst splitter: FSM states,
// default bus widths and the pending-counter width helper.
package avl_burst_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_BURST_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  // Enough bits to hold 0..maxPending outstanding reads.
  function automatic int pendingWidth(input int maxPending);
    return $clog2(maxPending + 1);
  endfunction

endpackage

// File: rtl/avl_burst_splitter.sv
// Splits Avalon-MM bursts into single-word transfers; writes pass straight
// through beat by beat, reads are issued pipelined and returned in order.
module avl_burst_splitter
  import avl_burst_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int MAX_PENDING = 4
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic [ADDR_WIDTH-1:0]  iS_ADDRESS,
  input  logic                   iS_WRITE,
  input  logic                   iS_READ,
  input  logic [DATA_WIDTH-1:0]  iS_WRITE_DATA,
  input  logic [BURST_WIDTH-1:0] iS_BURST_COUNT,
  output logic                   oS_WAIT_REQUEST,
  output logic [DATA_WIDTH-1:0]  oS_READ_DATA,
  output logic                   oS_READ_DATA_VALID,
  output logic [ADDR_WIDTH-1:0]  oM_ADDRESS,
  output logic                   oM_WRITE,
  output logic                   oM_READ,
  output logic [DATA_WIDTH-1:0]  oM_WRITE_DATA,
  input  logic [DATA_WIDTH-1:0]  iM_READ_DATA,
  input  logic                   iM_WAIT_REQUEST,
  input  logic                   iM_READ_DATA_VALID
);

  localparam int PW = pendingWidth(MAX_PENDING);
  localparam logic [PW-1:0] MAX_PEND = PW'(MAX_PENDING);

  state_t                 state, stateNext;
  logic [ADDR_WIDTH-1:0]  rADDR;
  logic [BURST_WIDTH-1:0] rREMAIN;
  logic [BURST_WIDTH-1:0] burstLen;
  logic [PW-1:0]          rPENDING, pendNext;
  logic                   rdReq, rdAccept, wrAccept;

  assign burstLen = (iS_BURST_COUNT == '0) ? BURST_WIDTH'(1) : iS_BURST_COUNT;

  // A return in the same cycle frees a slot, so a full window keeps streaming.
  assign rdReq    = (state == RD_ISSUE) && ((rPENDING < MAX_PEND) || iM_READ_DATA_VALID);
  assign rdAccept = rdReq && !iM_WAIT_REQUEST;
  assign wrAccept = oM_WRITE && !iM_WAIT_REQUEST;

  always_comb begin
    pendNext = rPENDING;
    if (rdAccept && !iM_READ_DATA_VALID)
      pendNext = rPENDING + 1'b1;
    else if (!rdAccept && iM_READ_DATA_VALID && (rPENDING != '0))
      pendNext = rPENDING - 1'b1;
  end

  always_comb begin
    stateNext       = state;
    oM_WRITE        = 1'b0;
    oM_READ         = rdReq;
    oM_ADDRESS      = rADDR;
    oM_WRITE_DATA   = iS_WRITE_DATA;
    oS_WAIT_REQUEST = 1'b0;
    case (state)
      IDLE: begin
        // Write wins over a simultaneous read; the read is dropped.
        if (iS_WRITE) begin
          oM_WRITE        = 1'b1;
          oM_ADDRESS      = iS_ADDRESS;
          oS_WAIT_REQUEST = iM_WAIT_REQUEST;
          if (!iM_WAIT_REQUEST && (burstLen > BURST_WIDTH'(1)))
            stateNext = WR_BURST;
        end else if (iS_READ) begin
          stateNext = RD_ISSUE;
        end
      end
      WR_BURST: begin
        oM_WRITE        = iS_WRITE;
        oS_WAIT_REQUEST = iM_WAIT_REQUEST;
        if (wrAccept && (rREMAIN == BURST_WIDTH'(1)))
          stateNext = IDLE;
      end
      RD_ISSUE: begin
        oS_WAIT_REQUEST = 1'b1;
        if (rdAccept && (rREMAIN == BURST_WIDTH'(1)))
          stateNext = (pendNext == '0) ? IDLE : RD_DRAIN;
      end
      RD_DRAIN: begin
        oS_WAIT_REQUEST = 1'b1;
        if (pendNext == '0)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= IDLE;
      rADDR    <= '0;
      rREMAIN  <= '0;
      rPENDING <= '0;
    end else begin
      state    <= stateNext;
      rPENDING <= pendNext;
      case (state)
        IDLE: begin
          if (iS_WRITE) begin
            if (!iM_WAIT_REQUEST) begin
              rADDR   <= iS_ADDRESS + 1'b1;
              rREMAIN <= burstLen - 1'b1;
            end
          end else if (iS_READ) begin
            rADDR   <= iS_ADDRESS;
            rREMAIN <= burstLen;
          end
        end
        WR_BURST: begin
          if (wrAccept) begin
            rADDR   <= rADDR + 1'b1;
            rREMAIN <= rREMAIN - 1'b1;
          end
        end
        RD_ISSUE: begin
          if (rdAccept) begin
            rADDR   <= rADDR + 1'b1;
            rREMAIN <= rREMAIN - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Return path is a plain register stage; it never back-pressures the peripheral.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oS_READ_DATA       <= '0;
      oS_READ_DATA_VALID <= 1'b0;
    end else begin
      oS_READ_DATA       <= iM_READ_DATA;
      oS_READ_DATA_VALID <= iM_READ_DATA_VALID;
    end
  end

endmodule

// File: tb/tb_avl_burst_splitter.sv
// Directed bench for avl_burst_splitter with a fixed-latency peripheral model.
module tb_avl_burst_splitter;

  localparam int MAXP = 2;

  logic        iCLK, iRESET;
  logic [31:0] iS_ADDRESS, iS_WRITE_DATA, oS_READ_DATA;
  logic        iS_WRITE, iS_READ, oS_WAIT_REQUEST, oS_READ_DATA_VALID;
  logic [4:0]  iS_BURST_COUNT;
  logic [31:0] oM_ADDRESS, oM_WRITE_DATA, iM_READ_DATA;
  logic        oM_WRITE, oM_READ, iM_WAIT_REQUEST, iM_READ_DATA_VALID;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;
  logic [31:0] rdQ[$];
  int          dueQ[$];

  avl_burst_splitter #(.MAX_PENDING(MAXP)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iS_ADDRESS(iS_ADDRESS), .iS_WRITE(iS_WRITE), .iS_READ(iS_READ),
    .iS_WRITE_DATA(iS_WRITE_DATA), .iS_BURST_COUNT(iS_BURST_COUNT),
    .oS_WAIT_REQUEST(oS_WAIT_REQUEST), .oS_READ_DATA(oS_READ_DATA),
    .oS_READ_DATA_VALID(oS_READ_DATA_VALID),
    .oM_ADDRESS(oM_ADDRESS), .oM_WRITE(oM_WRITE), .oM_READ(oM_READ),
    .oM_WRITE_DATA(oM_WRITE_DATA), .iM_READ_DATA(iM_READ_DATA),
    .iM_WAIT_REQUEST(iM_WAIT_REQUEST), .iM_READ_DATA_VALID(iM_READ_DATA_VALID)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] rdData(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Advance one cycle and drive the peripheral's read return for it.
  task automatic cycle();
    @(posedge iCLK);
    #1;
    cyc++;
    if (dueQ.size() != 0 && dueQ[0] <= cyc) begin
      iM_READ_DATA_VALID = 1'b1;
      iM_READ_DATA       = rdData(rdQ.pop_front());
      dueQ.delete(0);
    end else begin
      iM_READ_DATA_VALID = 1'b0;
      iM_READ_DATA       = '0;
    end
  endtask

  // Record an accepted master read into the peripheral model.
  task automatic note();
    if (oM_READ === 1'b1 && iM_WAIT_REQUEST === 1'b0) begin
      rdQ.push_back(oM_ADDRESS);
      dueQ.push_back(cyc + lat);
    end
  endtask

  task automatic test_reset();
    iRESET = 1'b1; iS_WRITE = 0; iS_READ = 0; iS_ADDRESS = '0;
    iS_WRITE_DATA = '0; iS_BURST_COUNT = '0; iM_WAIT_REQUEST = 0;
    iM_READ_DATA_VALID = 0; iM_READ_DATA = '0;
    repeat (2) @(posedge iCLK);
    #3;
    checks++;
    if (oS_WAIT_REQUEST !== 1'b0 || oM_READ !== 1'b0 || oM_WRITE !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got wait=%b rd=%b wr=%b want 0 0 0", oS_WAIT_REQUEST, oM_READ, oM_WRITE);
    end
    checks++;
    if (oS_READ_DATA_VALID !== 1'b0 || oS_READ_DATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_ret got vld=%b data=%h want 0 0", oS_READ_DATA_VALID, oS_READ_DATA);
    end
    iRESET = 1'b0;
  endtask

  task automatic test_write(input logic [31:0] base, input logic [4:0] cnt, input int n,
                            input int stall, input int gapAfter, input string name);
    logic [31:0] ea, ed;
    for (int k = 0; k < n; k++) begin
      if (k == gapAfter) begin
        cycle(); iS_WRITE = 0; iM_WAIT_REQUEST = 0; #2;
        checks++;
        if (oM_WRITE !== 1'b0) begin
          errors++; $display("FAIL %s_gap oM_WRITE got %b want 0", name, oM_WRITE);
        end
        note();
      end
      for (int s = 0; s <= stall; s++) begin
        ea = base + 32'(k);
        ed = 32'hDA7A_0000 + 32'(k);
        cycle();
        iS_WRITE = 1; iS_READ = 0; iS_ADDRESS = base; iS_BURST_COUNT = cnt;
        iS_WRITE_DATA = ed; iM_WAIT_REQUEST = (s < stall);
        #2;
        checks++;
        if (oM_WRITE !== 1'b1 || oM_READ !== 1'b0) begin
          errors++; $display("FAIL %s_req beat %0d got wr=%b rd=%b want 1 0", name, k, oM_WRITE, oM_READ);
        end
        checks++;
        if (oM_ADDRESS !== ea || oM_WRITE_DATA !== ed) begin
          errors++;
          $display("FAIL %s_beat %0d got addr=%h data=%h want %h %h", name, k, oM_ADDRESS, oM_WRITE_DATA, ea, ed);
        end
        checks++;
        if (oS_WAIT_REQUEST !== (s < stall)) begin
          errors++; $display("FAIL %s_wait beat %0d got %b want %b", name, k, oS_WAIT_REQUEST, (s < stall));
        end
        note();
      end
    end
    // Back in IDLE a peripheral stall must not reach the slave side.
    cycle(); iS_WRITE = 0; iM_WAIT_REQUEST = 1; #2;
    checks++;
    if (oS_WAIT_REQUEST !== 1'b0 || oM_WRITE !== 1'b0) begin
      errors++; $display("FAIL %s_idle got wait=%b wr=%b want 0 0", name, oS_WAIT_REQUEST, oM_WRITE);
    end
    note();
    iM_WAIT_REQUEST = 0;
  endtask

  task automatic test_read(input logic [31:0] base, input logic [4:0] cnt, input int nExp,
                           input int latency, input string name);
    int acc = 0, vldSeen = 0, ret = 0;
    bit pv, done, expRd, expWait;
    logic [31:0] ea;
    done = 0;
    lat = latency;
    cycle(); iS_READ = 1; iS_WRITE = 0; iS_ADDRESS = base; iS_BURST_COUNT = cnt; #2;
    checks++;
    if (oS_WAIT_REQUEST !== 1'b0 || oM_READ !== 1'b0) begin
      errors++; $display("FAIL %s_cmd got wait=%b rd=%b want 0 0", name, oS_WAIT_REQUEST, oM_READ);
    end
    note();
    for (int c = 0; c < 300 && !done; c++) begin
      pv = iM_READ_DATA_VALID;
      cycle(); iS_READ = 0; #2;
      expRd   = (acc < nExp) && (((acc - vldSeen) < MAXP) || iM_READ_DATA_VALID);
      expWait = !(acc == nExp && (acc - vldSeen) == 0);
      ea = base + 32'(acc);
      checks++;
      if (oM_READ !== expRd) begin
        errors++; $display("FAIL %s_issue cyc %0d got rd=%b want %b", name, c, oM_READ, expRd);
      end
      if (expRd) begin
        checks++;
        if (oM_ADDRESS !== ea) begin
          errors++; $display("FAIL %s_addr got %h want %h", name, oM_ADDRESS, ea);
        end
      end
      checks++;
      if (oS_WAIT_REQUEST !== expWait) begin
        errors++; $display("FAIL %s_wait cyc %0d got %b want %b", name, c, oS_WAIT_REQUEST, expWait);
      end
      checks++;
      if (oS_READ_DATA_VALID !== pv) begin
        errors++; $display("FAIL %s_rvalid cyc %0d got %b want %b", name, c, oS_READ_DATA_VALID, pv);
      end
      if (oS_READ_DATA_VALID === 1'b1) begin
        checks++;
        if (oS_READ_DATA !== rdData(base + 32'(ret))) begin
          errors++;
          $display("FAIL %s_rdata %0d got %h want %h", name, ret, oS_READ_DATA, rdData(base + 32'(ret)));
        end
        ret++;
      end
      if (iM_READ_DATA_VALID) vldSeen++;
      if (oM_READ === 1'b1 && iM_WAIT_REQUEST === 1'b0) acc++;
      note();
      if (!expWait) done = 1;
    end
    checks++;
    if (!done || ret != nExp || acc != nExp) begin
      errors++; $display("FAIL %s_done got done=%0d ret=%0d acc=%0d want 1 %0d %0d", name, done, ret, acc, nExp, nExp);
    end
  endtask

  task automatic test_rd_wr_collision();
    cycle(); iS_READ = 1; iS_WRITE = 1; iS_ADDRESS = 32'h300; iS_BURST_COUNT = 5'd1;
    iS_WRITE_DATA = 32'h5555_AAAA; #2;
    checks++;
    if (oM_WRITE !== 1'b1 || oM_READ !== 1'b0 || oM_ADDRESS !== 32'h300) begin
      errors++; $display("FAIL collide_wr got wr=%b rd=%b addr=%h want 1 0 00000300", oM_WRITE, oM_READ, oM_ADDRESS);
    end
    note();
    cycle(); iS_READ = 0; iS_WRITE = 0; iM_WAIT_REQUEST = 1; #2;
    checks++;
    if (oS_WAIT_REQUEST !== 1'b0 || oM_READ !== 1'b0) begin
      errors++; $display("FAIL collide_idle got wait=%b rd=%b want 0 0", oS_WAIT_REQUEST, oM_READ);
    end
    note();
    iM_WAIT_REQUEST = 0;
  endtask

  task automatic test_reset_midop();
    int stale = 0;
    lat = 5;
    cycle(); iS_READ = 1; iS_ADDRESS = 32'h200; iS_BURST_COUNT = 5'd4; #2; note();
    for (int c = 0; c < 3; c++) begin
      cycle(); iS_READ = 0; #2;
      checks++;
      if (oM_READ !== (c < 2)) begin
        errors++; $display("FAIL midop_issue %0d got %b want %b", c, oM_READ, (c < 2));
      end
      note();
    end
    #1 iRESET = 1'b1;
    #1;
    checks++;
    if (oM_READ !== 1'b0 || oS_WAIT_REQUEST !== 1'b0 || oS_READ_DATA_VALID !== 1'b0 || oS_READ_DATA !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset got rd=%b wait=%b vld=%b data=%h want 0 0 0 0",
               oM_READ, oS_WAIT_REQUEST, oS_READ_DATA_VALID, oS_READ_DATA);
    end
    cycle(); iRESET = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle(); #2;
      checks++;
      if (oS_WAIT_REQUEST !== 1'b0 || oM_READ !== 1'b0) begin
        errors++; $display("FAIL midop_idle %0d got wait=%b rd=%b want 0 0", c, oS_WAIT_REQUEST, oM_READ);
      end
      if (oS_READ_DATA_VALID === 1'b1) stale++;
      note();
    end
    checks++;
    if (stale != 2) begin
      errors++; $display("FAIL midop_stale got %0d want 2", stale);
    end
  endtask

  initial begin
    test_reset();
    test_write(32'h0000_0100, 5'd4, 4, 0, -1, "wr4");
    test_read (32'h0000_0020, 5'd3, 3, 2, "rd3");
    test_read (32'h0000_1000, 5'd16, 16, 5, "rd16");
    test_write(32'hFFFF_FFFF, 5'd2, 2, 3, -1, "wrwrap");
    test_read (32'h0000_0040, 5'd0, 1, 3, "rd0");
    test_write(32'h0000_0500, 5'd3, 3, 1, 1, "wrgap");
    test_rd_wr_collision();
    test_reset_midop();
    test_write(32'h0000_0700, 5'd1, 1, 0, -1, "wrpost");
    test_read (32'h0000_0600, 5'd2, 2, 5, "rdpost");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/avl_burst_splitter.md
Name: avl_burst_splitter

Overview:
- Sits directly downstream of the JTAG-to-Avalon bursting master.
- Accepts Avalon-MM bursts (word addressed, burstcount 1..16) on its slave side.
- Re-issues each burst on its master side as single-word transfers at incrementing word addresses, for peripherals without burst support.
- Tracks outstanding pipelined reads and forwards read data back to the bursting master in order.

Parameters:
- ADDR_WIDTH, 32, word-address width on both sides
- DATA_WIDTH, 32, data width on both sides
- BURST_WIDTH, 5, slave burstcount width
- MAX_PENDING, 4, maximum outstanding single reads on the master side (1..15)

Ports:
- iCLK  in  1  system clock
- iRESET  in  1  asynchronous active-high reset
- iS_ADDRESS  in  ADDR_WIDTH  burst start word address (valid on first beat / read command)
- iS_WRITE  in  1  slave write beat request
- iS_READ  in  1  slave read burst request
- iS_WRITE_DATA  in  DATA_WIDTH  write beat data
- iS_BURST_COUNT  in  BURST_WIDTH  burst length, sampled on first beat
- oS_WAIT_REQUEST  out  1  slave stall
- oS_READ_DATA  out  DATA_WIDTH  returned read word
- oS_READ_DATA_VALID  out  1  oS_READ_DATA qualifier
- oM_ADDRESS  out  ADDR_WIDTH  single-transfer word address
- oM_WRITE  out  1  master write request
- oM_READ  out  1  master read request
- oM_WRITE_DATA  out  DATA_WIDTH  master write data
- iM_READ_DATA  in  DATA_WIDTH  peripheral read data
- iM_WAIT_REQUEST  in  1  peripheral stall
- iM_READ_DATA_VALID  in  1  peripheral read data qualifier

Behaviour:
- Clock and reset: one clock, iCLK; reset iRESET, asynchronous and active-high.
- Reset values: state IDLE, rADDR=0, rREMAIN=0, rPENDING=0, oS_READ_DATA=0, oS_READ_DATA_VALID=0. oM_READ=oM_WRITE=0. oS_WAIT_REQUEST=0 in IDLE.
- Burstcount 0 is treated as 1.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is legal.
- States: IDLE, WR_BURST, RD_ISSUE, RD_DRAIN.
- IDLE, iS_WRITE=1 (first beat):
  - Passthrough: oM_WRITE=1, oM_ADDRESS=iS_ADDRESS, oM_WRITE_DATA=iS_WRITE_DATA, oS_WAIT_REQUEST=iM_WAIT_REQUEST.
  - On accept (!iM_WAIT_REQUEST): rADDR<=iS_ADDRESS+1, rREMAIN<=count-1.
  - If count<=1, stay IDLE; else go to WR_BURST.
- WR_BURST:
  - oM_WRITE=iS_WRITE, oM_ADDRESS=rADDR, data passthrough, oS_WAIT_REQUEST=iM_WAIT_REQUEST.
  - Each accepted beat: rADDR+1, rREMAIN-1.
  - On the beat where rREMAIN==1 is accepted, go to IDLE.
  - Zero added latency on the write path.
- IDLE, iS_READ=1 (and iS_WRITE=0):
  - oS_WAIT_REQUEST=0 that cycle; command accepted.
  - Latch rADDR<=iS_ADDRESS, rREMAIN<=count; go to RD_ISSUE.
- RD_ISSUE:
  - oS_WAIT_REQUEST=1.
  - oM_READ=1 when rPENDING<MAX_PENDING (counting a same-cycle return as freeing a slot), oM_ADDRESS=rADDR.
  - On accept: rADDR+1, rREMAIN-1.
  - When the last read is accepted: go to RD_DRAIN, or to IDLE if no read remains pending after that cycle.
- RD_DRAIN: oS_WAIT_REQUEST=1, no master requests; go to IDLE when rPENDING reaches 0.
- Pending counter:
  - +1 on accepted master read, -1 on iM_READ_DATA_VALID; both in the same cycle leave it unchanged.
  - Saturates at 0 on an unexpected valid.
- Read return: oS_READ_DATA/oS_READ_DATA_VALID are registered copies of iM_READ_DATA/iM_READ_DATA_VALID; fixed 1-cycle latency, order preserved, never stalled.
- Simultaneous iS_READ and iS_WRITE in IDLE (protocol violation): the write is serviced and the read is ignored.
- iS_WRITE=0 inside WR_BURST: hold state, no master write issued.
- Reset mid-operation: immediate return to IDLE with counters cleared. Read data arriving after reset is still forwarded; the counter stays at 0.

Decomposition:
- Package avl_burst_pkg:
  - state enum (IDLE, WR_BURST, RD_ISSUE, RD_DRAIN)
  - default width constants (ADDR_WIDTH, DATA_WIDTH, BURST_WIDTH)
  - PENDING_WIDTH = clog2(MAX_PENDING+1)
- No sub-module: FSM, two counters and the return register fit in one module.

Test Plan:
- Write burst addr=0x100, count=4, data A0..A3, iM_WAIT_REQUEST=0 -> four oM_WRITE cycles at 0x100..0x103 with A0..A3; state back to IDLE after the 4th beat.
- Read burst addr=0x20, count=3, peripheral latency 2, MAX_PENDING=4 -> reads at 0x20,0x21,0x22 back-to-back. Three oS_READ_DATA_VALID pulses in order, each 1 cycle after the matching iM_READ_DATA_VALID. oS_WAIT_REQUEST drops once rPENDING=0.
- Read burst count=16, MAX_PENDING=2, peripheral latency 5 -> never more than 2 outstanding; 16 returns in order; addresses 0..15 relative to base.
- Write count=2 at 0xFFFFFFFF with iM_WAIT_REQUEST high for 3 cycles on each beat -> oS_WAIT_REQUEST mirrors the stall; writes land at 0xFFFFFFFF then 0x00000000.
- Burstcount 0 read at 0x40 -> exactly one master read at 0x40 and one returned word.
- Assert iRESET during RD_ISSUE with 2 reads pending -> outputs at reset values immediately, state IDLE. A subsequent write burst count=1 executes normally.
